// File: rtl/cic_pkg.sv
// Shared CIC definitions: rate/phase type, default decimation rate and the
// output-register state encoding used by the decimation scheduler.
package cic_pkg;

  localparam int RATE_BITS = 8;
  localparam int WORD_BITS = 29;

  typedef logic [RATE_BITS-1:0] rate_t;

  // Also consumed by the gain-compensation logic, so keep it a package constant.
  localparam rate_t DEFAULT_RATE = rate_t'(8);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  // Rate 0 is meaningless for a decimator; treat it as pass-through.
  function automatic rate_t clamp_rate(input rate_t r);
    return (r == '0) ? rate_t'(1) : r;
  endfunction

endpackage

// File: rtl/cic_rate_ctrl.sv
// Decimation-rate control: captures requested rates into a pending register
// and commits them to the active rate only at a decimation-phase boundary.
module cic_rate_ctrl
  import cic_pkg::*;
#(
  parameter int RateBits    = RATE_BITS,
  parameter int DefaultRate = int'(DEFAULT_RATE)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [RateBits-1:0] rate_in,
  input  logic                rate_load,
  input  logic                boundary,
  output logic [RateBits-1:0] rate_active
);

  localparam logic [RateBits-1:0] RateOne   = {{(RateBits-1){1'b0}}, 1'b1};
  localparam logic [RateBits-1:0] RateReset = DefaultRate[RateBits-1:0];

  logic [RateBits-1:0] pending_rate;
  logic                pending_valid;
  logic [RateBits-1:0] rate_in_clamped;
  logic [RateBits-1:0] next_rate;
  logic                next_valid;

  // A load in the same cycle as a boundary wins over the older pending value.
  always_comb begin
    rate_in_clamped = (rate_in == '0) ? RateOne : rate_in;
    next_rate       = rate_load ? rate_in_clamped : pending_rate;
    next_valid      = rate_load | pending_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rate_active   <= RateReset;
      pending_rate  <= '0;
      pending_valid <= 1'b0;
    end else if (boundary && next_valid) begin
      rate_active   <= next_rate;
      pending_valid <= 1'b0;
    end else if (rate_load) begin
      pending_rate  <= rate_in_clamped;
      pending_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/cic_decimation_scheduler.sv
// Sequencer between CIC integrators and comb chain: keeps every R-th sample,
// hands it over with valid/ready, and counts samples lost to backpressure.
//
// state | meaning
// EMPTY | no word held, out_valid low
// FULL  | decimated word held on out until out_ready transfers it
module cic_decimation_scheduler
  import cic_pkg::*;
#(
  parameter int WordLengthBits = WORD_BITS,
  parameter int RateBits       = RATE_BITS,
  parameter int DefaultRate    = int'(DEFAULT_RATE)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WordLengthBits-1:0] in,
  input  logic                      in_valid,
  input  logic [RateBits-1:0]       rate_in,
  input  logic                      rate_load,
  input  logic                      flush,
  output logic [WordLengthBits-1:0] out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [RateBits-1:0]       rate_active,
  output logic [RateBits-1:0]       phase,
  output logic                      overrun,
  output logic [7:0]                drop_count
);

  out_state_e state;
  logic       wrap;
  logic       boundary;
  logic       xfer;

  always_comb begin
    wrap     = in_valid & ~flush & (phase == rate_active - 1'b1);
    boundary = flush | wrap | ((phase == '0) & ~in_valid);
    xfer     = out_valid & out_ready;
  end

  cic_rate_ctrl #(
    .RateBits    (RateBits),
    .DefaultRate (DefaultRate)
  ) u_rate_ctrl (
    .clk         (clk),
    .rst         (rst),
    .rate_in     (rate_in),
    .rate_load   (rate_load),
    .boundary    (boundary),
    .rate_active (rate_active)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= '0;
    end else if (flush) begin
      phase <= '0;
    end else if (in_valid) begin
      phase <= wrap ? '0 : phase + 1'b1;
    end
  end

  // Integrators cannot be stalled, so a blocked decimated word is dropped
  // rather than back-pressured; the held word always stays stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      out        <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
      drop_count <= '0;
    end else begin
      overrun <= 1'b0;
      if (flush) begin
        state     <= EMPTY;
        out_valid <= 1'b0;
      end else begin
        case (state)
          EMPTY: begin
            if (wrap) begin
              out       <= in;
              out_valid <= 1'b1;
              state     <= FULL;
            end
          end
          FULL: begin
            if (wrap && xfer) begin
              out <= in;
            end else if (xfer) begin
              out_valid <= 1'b0;
              state     <= EMPTY;
            end else if (wrap) begin
              overrun <= 1'b1;
              if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
            end
          end
          default: begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cic_decimation_scheduler.sv
// Directed and randomized bench for cic_decimation_scheduler against a
// cycle-level behavioural model of the decimation rules.
module tb_cic_decimation_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [28:0] in = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  rate_in = '0;
  logic        rate_load = 1'b0;
  logic        flush = 1'b0;
  logic [28:0] out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  rate_active;
  logic [7:0]  phase;
  logic        overrun;
  logic [7:0]  drop_count;

  int passed = 0;
  int total  = 0;

  // Behavioural model state
  logic [28:0] m_out;
  bit          m_valid;
  int          m_phase;
  int          m_rate;
  bit          m_pend_v;
  int          m_pend;
  int          m_drop;
  bit          m_ovr;

  always #5 clk = ~clk;

  cic_decimation_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .in          (in),
    .in_valid    (in_valid),
    .rate_in     (rate_in),
    .rate_load   (rate_load),
    .flush       (flush),
    .out         (out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .rate_active (rate_active),
    .phase       (phase),
    .overrun     (overrun),
    .drop_count  (drop_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Advance the model by one clock using the inputs about to be sampled.
  task automatic model_step(input bit iv, input logic [28:0] d, input bit rdy,
                            input bit ld, input int ri, input bit fl, input bit r);
    bit decim;
    bit apply;
    bit xf;
    if (r) begin
      m_out = '0; m_valid = 0; m_phase = 0; m_rate = 8;
      m_pend_v = 0; m_pend = 0; m_drop = 0; m_ovr = 0;
      return;
    end
    if (ld) begin
      m_pend   = (ri == 0) ? 1 : ri;
      m_pend_v = 1;
    end
    decim = iv && !fl && (m_phase + 1 == m_rate);
    apply = fl || decim || (m_phase == 0 && !iv);
    xf    = m_valid && rdy;
    m_ovr = 0;
    if (fl) begin
      m_valid = 0;
    end else if (decim) begin
      if (!m_valid || xf) begin
        m_out   = d;
        m_valid = 1;
      end else begin
        m_ovr  = 1;
        m_drop = (m_drop < 255) ? m_drop + 1 : 255;
      end
    end else if (xf) begin
      m_valid = 0;
    end
    if (fl)          m_phase = 0;
    else if (decim)  m_phase = 0;
    else if (iv)     m_phase = m_phase + 1;
    if (apply && m_pend_v) begin
      m_rate   = m_pend;
      m_pend_v = 0;
    end
  endtask

  task automatic cyc(input bit iv, input logic [28:0] d, input bit rdy,
                     input bit ld = 0, input int ri = 0, input bit fl = 0, input bit r = 0);
    in_valid  = iv;
    in        = d;
    out_ready = rdy;
    rate_load = ld;
    rate_in   = ri[7:0];
    flush     = fl;
    rst       = r;
    model_step(iv, d, rdy, ld, ri, fl, r);
    @(posedge clk);
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    chk("out", {3'd0, out}, {3'd0, m_out});
    chk("phase", {24'd0, phase}, m_phase);
    chk("rate_active", {24'd0, rate_active}, m_rate);
    chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
    chk("drop_count", {24'd0, drop_count}, m_drop);
  endtask

  initial begin
    m_out = '0; m_valid = 0; m_phase = 0; m_rate = 8;
    m_pend_v = 0; m_pend = 0; m_drop = 0; m_ovr = 0;

    // Reset and fixed reset values
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("reset_rate", {24'd0, rate_active}, 8);
    chk("reset_valid", {31'd0, out_valid}, 0);

    // R=4, samples 1..12, out_ready high
    cyc(0, 0, 1, 1, 4);
    chk("rate_set4", {24'd0, rate_active}, 4);
    for (int i = 1; i <= 12; i++) begin
      cyc(1, 29'(i), 1);
      if (i % 4 == 0) begin
        chk("dec_out", {3'd0, out}, i);
        chk("dec_valid", {31'd0, out_valid}, 1);
      end
    end
    cyc(0, 0, 1);
    chk("no_drops", {24'd0, drop_count}, 0);

    // Backpressure across two periods
    for (int i = 1; i <= 8; i++) cyc(1, 29'(i), 0);
    chk("bp_hold", {3'd0, out}, 4);
    chk("bp_overrun", {31'd0, overrun}, 1);
    chk("bp_drop", {24'd0, drop_count}, 1);
    cyc(0, 0, 0);
    chk("bp_pulse_once", {31'd0, overrun}, 0);
    cyc(0, 0, 1);
    chk("bp_release", {31'd0, out_valid}, 0);

    // Transfer and new decimated word in the same cycle
    for (int i = 1; i <= 7; i++) cyc(1, 29'(100 + i), 0);
    cyc(1, 29'd108, 1);
    chk("same_cyc_out", {3'd0, out}, 108);
    chk("same_cyc_valid", {31'd0, out_valid}, 1);
    chk("same_cyc_ovr", {31'd0, overrun}, 0);
    cyc(0, 0, 1);

    // Rate change mid-period, then rate_in=0 clamps to 1
    cyc(1, 29'd1, 1);
    cyc(1, 29'd2, 1);
    cyc(0, 0, 1, 1, 2);
    chk("pending_not_yet", {24'd0, rate_active}, 4);
    for (int i = 3; i <= 10; i++) begin
      cyc(1, 29'(i), 1);
      if (i == 4) chk("old_rate_out", {3'd0, out}, 4);
      if (i == 6 || i == 8 || i == 10) chk("new_rate_out", {3'd0, out}, i);
    end
    chk("rate2", {24'd0, rate_active}, 2);
    cyc(0, 0, 1, 1, 0);
    chk("rate_clamp1", {24'd0, rate_active}, 1);
    for (int i = 1; i <= 4; i++) begin
      cyc(1, 29'(50 + i), 1);
      chk("pass_thru", {3'd0, out}, 50 + i);
    end
    cyc(0, 0, 1);

    // Flush at phase 3 with a held word
    cyc(0, 0, 1, 1, 4);
    for (int i = 1; i <= 7; i++) cyc(1, 29'(200 + i), 0);
    chk("pre_flush_phase", {24'd0, phase}, 3);
    cyc(1, 29'd999, 0, 0, 0, 1);
    chk("flush_phase", {24'd0, phase}, 0);
    chk("flush_valid", {31'd0, out_valid}, 0);
    chk("flush_drop", {24'd0, drop_count}, 1);
    for (int i = 1; i <= 4; i++) cyc(1, 29'(300 + i), 1);
    chk("post_flush_out", {3'd0, out}, 304);
    cyc(0, 0, 1);

    // Reset while FULL with a pending rate
    for (int i = 1; i <= 5; i++) cyc(1, 29'(400 + i), 0);
    cyc(0, 0, 0, 1, 3);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_out", {3'd0, out}, 0);
    chk("rst_rate", {24'd0, rate_active}, 8);
    chk("rst_drop", {24'd0, drop_count}, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("pending_discarded", {24'd0, rate_active}, 8);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      bit iv, rdy, ld, fl;
      iv  = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      ld  = ($urandom_range(0, 29) == 0);
      fl  = ($urandom_range(0, 59) == 0);
      cyc(iv, 29'($urandom), rdy, ld, int'($urandom_range(0, 5)), fl);
    end

    // Sustained R=1 with ready high never overruns
    cyc(0, 0, 1, 1, 1, 1);
    for (int i = 0; i < 20; i++) begin
      cyc(1, 29'($urandom), 1);
      chk("r1_no_overrun", {31'd0, overrun}, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
